audio_sample_to_indicator_position: RTL and testbench
=====================================================

# audio_sample_to_indicator_position

Upstream stage of the level-meter pipeline. Accepts signed stereo PCM frames and tracks the per-channel peak magnitude over a fixed number of frames. At the end of each window it converts each peak to a logarithmic (3 dB step) indicator position and emits it, left then right. The output handshake feeds the position-to-meter stage directly via `o_valid`/`o_ready`, `o_is_left` and `o_position`.

## Interface
- `sample_width`, 16: PCM sample width (signed two's complement).
- `width`, 32: number of meter segments downstream; requires `2*sample_width >= width`.
- `decimation`, 256: frames per peak window; must be ≥ 2.
- `clk` input 1: rising-edge clock, single domain.
- `reset` input 1: synchronous, active-low; sampled on `clk`, asserted when 0.
- `i_valid` input 1: frame valid.
- `i_ready` output 1: frame accepted when `i_valid && i_ready` at a rising edge.
- `i_left` input `sample_width`: left sample, signed.
- `i_right` input `sample_width`: right sample, signed.
- `o_valid` output 1: position valid.
- `o_ready` input 1: downstream accepts.
- `o_is_left` output 1: 1 = left channel, 0 = right channel.
- `o_position` output `$clog2(width)`: indicator position, 0..`width-1`.

## Operation
- **Magnitude.**
  - `mag = |sample|`, unsigned, `sample_width` bits.
  - The most negative value maps to `2^(sample_width-1)`; no overflow.
- **Peak accumulation.**
  - On each accepted frame: `acc_l = max(acc_l, mag_l)`, `acc_r = max(acc_r, mag_r)`, `frame_cnt++`.
  - On the frame that makes `frame_cnt == decimation`:
    - the updated maxima are copied to `pk_l`/`pk_r`;
    - `acc_*` and `frame_cnt` clear to 0 in the same cycle;
    - a conversion pair is started.
- **Level.**
  - For `mag == 0`: `L = 0`.
  - Otherwise `L = 2*k + b + 1`, where `k` is the index of the leading one and `b = mag[k-1]` (b = 0 when k = 0).
  - `o_position = L - (2*sample_width - width)`, clamped to 0 when negative.
- **FSM states.**
  - `IDLE`: waits for a conversion start. On start, goes to `SCAN` with `ch = left` and `idx = sample_width-1`.
  - `SCAN`: one bit per cycle. If `pk[ch][idx]` is 1 or `idx == 0`, it latches `o_position` and `o_is_left` and goes to `EMIT`. Otherwise it decrements `idx`.
  - `EMIT`: holds `o_valid` = 1 with stable `o_position`/`o_is_left` until `o_ready`.
    - On acceptance after left: goes to `SCAN` with `ch = right` and `idx = sample_width-1`.
    - On acceptance after right: goes to `IDLE`.
- **Back-pressure.**
  - `i_ready` = 0 only when `frame_cnt == decimation-1` and the FSM is not in `IDLE`. The window-closing frame is held off until the previous pair has fully drained.
  - All other frames are accepted during conversion. The `pk_*` registers are not written until the FSM returns to `IDLE`.

## Timing
- **Reset (`reset` = 0 at an edge):**
  - `i_ready` = 0, `o_valid` = 0, `o_is_left` = 0, `o_position` = 0.
  - `acc_*`, `pk_*` and `frame_cnt` clear to 0; the FSM goes to `IDLE`.
  - Reset mid-window or mid-handshake discards everything, with no partial output.
  - `i_ready` = 1 from the first edge after `reset` = 1.
- **Scan duration:** `SCAN` lasts `sample_width - k` cycles for `mag > 0` and `sample_width` cycles for `mag == 0`.
- **First output latency:** `o_valid` rises on the edge after the last `SCAN` cycle. The window-closing frame is accepted at edge T; `IDLE` → `SCAN` at T+1; the first `o_valid` = 1 follows at T+1+scan_cycles.
- **Output handshake:** `o_valid` never drops without `o_ready`, and outputs stay stable while stalled. The right channel scan begins on the edge after left acceptance.
- **Simultaneous events:**
  - A frame accepted in the same cycle as the right channel acceptance is allowed.
  - If that frame closes the window, the conversion start takes effect from `IDLE` on the next edge.

## Structure
- Shared package `audio_level_meter_pkg`:
  - FSM state encodings (`IDLE`/`SCAN`/`EMIT`);
  - the position-width function `$clog2(width)`, shared with the position-to-meter stage.
- One sub-module, `peak_accumulator`: two `max` registers plus `frame_cnt`, with a `window_done` pulse and the latched peaks.
- The scan FSM and level arithmetic live in the top module.

## Test plan
All cases use `sample_width` = 16, `width` = 32, `decimation` = 2, with `o_ready` = 1 unless stated.
- Frames (L = 0x7FFF, R = 0x8000), then (0, 0) → left position 30, then right position 31; left `SCAN` lasts 2 cycles, right `SCAN` lasts 1 cycle.
- Frames (1, 0x0003), then (0xFFFD, 0) → left 4 (peak 3), right 4.
- All-zero window → left 0, right 0, each after a 16-cycle `SCAN`.
- L = 0x00C0, R = 0x0001 with `o_ready` held 0 for 10 cycles → left `o_valid` stays 1 with position 16 throughout; right 1 follows after release.
- Continuous `i_valid` with `o_ready` held 0 → `i_ready` = 0 on the window-closing frame until the right channel is accepted, and no frame is lost (frame count checked).
- `reset` = 0 during `EMIT` → next edge `o_valid` = 0 and `i_ready` = 0; after release, a fresh window produces correct positions.

Source files
------------

// File: rtl/audio_level_meter_pkg.sv
// rtl/audio_level_meter_pkg.sv - shared types and helpers for the level-meter pipeline
package audio_level_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } meter_state_t;

  function automatic int position_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/peak_accumulator.sv
// rtl/peak_accumulator.sv - per-channel peak magnitude over a window of frames
module peak_accumulator #(
  parameter int sample_width = 16,
  parameter int decimation   = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    accept,
  input  logic [sample_width-1:0] mag_l,
  input  logic [sample_width-1:0] mag_r,
  output logic                    last_frame,
  output logic                    window_done,
  output logic [sample_width-1:0] pk_l,
  output logic [sample_width-1:0] pk_r
);

  localparam int CW = $clog2(decimation);

  logic [sample_width-1:0] acc_l, acc_r;
  logic [sample_width-1:0] max_l, max_r;
  logic [CW-1:0]           frame_cnt;

  assign max_l      = (mag_l > acc_l) ? mag_l : acc_l;
  assign max_r      = (mag_r > acc_r) ? mag_r : acc_r;
  assign last_frame = (frame_cnt == CW'(decimation - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_l       <= '0;
      acc_r       <= '0;
      pk_l        <= '0;
      pk_r        <= '0;
      frame_cnt   <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (accept) begin
        if (last_frame) begin
          // the closing frame's own magnitude counts toward the published peak
          pk_l        <= max_l;
          pk_r        <= max_r;
          acc_l       <= '0;
          acc_r       <= '0;
          frame_cnt   <= '0;
          window_done <= 1'b1;
        end else begin
          acc_l     <= max_l;
          acc_r     <= max_r;
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/audio_sample_to_indicator_position.sv
// rtl/audio_sample_to_indicator_position.sv - windowed stereo peak to 3 dB-step indicator position
module audio_sample_to_indicator_position
  import audio_level_meter_pkg::*;
#(
  parameter int sample_width = 16,
  parameter int width        = 32,
  parameter int decimation   = 256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [sample_width-1:0]           i_left,
  input  logic [sample_width-1:0]           i_right,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic                              o_is_left,
  output logic [position_width(width)-1:0]  o_position
);

  localparam int PW     = position_width(width);
  localparam int IW     = $clog2(sample_width);
  localparam int LW     = $clog2(2 * sample_width) + 1;
  localparam int OFFSET = 2 * sample_width - width;
  localparam logic [IW-1:0] TOP_IDX = IW'(sample_width - 1);

  function automatic logic [sample_width-1:0] magnitude(input logic [sample_width-1:0] s);
    return s[sample_width-1] ? (~s + sample_width'(1)) : s;
  endfunction

  meter_state_t            state, state_n;
  logic                    ch_right, ch_right_n;
  logic [IW-1:0]           idx, idx_n;
  logic [PW-1:0]           pos_n;
  logic                    is_left_n;
  logic                    ready_en;
  logic                    accept, last_frame, window_done;
  logic [sample_width-1:0] pk_l, pk_r, cur_pk;
  logic                    bit_below;
  logic [LW-1:0]           level;
  logic [PW-1:0]           scan_pos;

  // the window-closing frame waits until the previous pair has drained
  assign i_ready = ready_en && !(last_frame && (state != IDLE));
  assign accept  = i_valid && i_ready;
  assign o_valid = (state == EMIT);

  peak_accumulator #(
    .sample_width(sample_width),
    .decimation  (decimation)
  ) u_peak (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .mag_l      (magnitude(i_left)),
    .mag_r      (magnitude(i_right)),
    .last_frame (last_frame),
    .window_done(window_done),
    .pk_l       (pk_l),
    .pk_r       (pk_r)
  );

  // level = 2k + (bit below leading one) + 1, shifted down to the meter range
  always_comb begin
    cur_pk    = ch_right ? pk_r : pk_l;
    bit_below = (idx != '0) ? cur_pk[idx - IW'(1)] : 1'b0;
    level     = '0;
    if (cur_pk[idx]) level = (LW'(idx) << 1) + LW'(bit_below) + LW'(1);
    scan_pos = '0;
    if (level > LW'(OFFSET)) scan_pos = PW'(level - LW'(OFFSET));
  end

  always_comb begin
    state_n    = state;
    ch_right_n = ch_right;
    idx_n      = idx;
    pos_n      = o_position;
    is_left_n  = o_is_left;
    case (state)
      IDLE: begin
        if (window_done) begin
          state_n    = SCAN;
          ch_right_n = 1'b0;
          idx_n      = TOP_IDX;
        end
      end
      SCAN: begin
        if (cur_pk[idx] || (idx == '0)) begin
          pos_n     = scan_pos;
          is_left_n = !ch_right;
          state_n   = EMIT;
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      EMIT: begin
        if (o_ready) begin
          if (!ch_right) begin
            state_n    = SCAN;
            ch_right_n = 1'b1;
            idx_n      = TOP_IDX;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ch_right   <= 1'b0;
      idx        <= TOP_IDX;
      o_position <= '0;
      o_is_left  <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_n;
      ch_right   <= ch_right_n;
      idx        <= idx_n;
      o_position <= pos_n;
      o_is_left  <= is_left_n;
      ready_en   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_to_indicator_position.sv
// tb/tb_audio_sample_to_indicator_position.sv - directed self-checking bench for the indicator stage
module tb_audio_sample_to_indicator_position;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [15:0] i_left = '0;
  logic [15:0] i_right = '0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic        o_is_left;
  logic [4:0]  o_position;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  int base;
  int stall;

  audio_sample_to_indicator_position #(
    .sample_width(16),
    .width       (32),
    .decimation  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_left    (i_left),
    .i_right   (i_right),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_is_left (o_is_left),
    .o_position(o_position)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && i_valid && i_ready) accepted <= accepted + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge, i_valid left high
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, output int waited);
    i_left  = l;
    i_right = r;
    i_valid = 1'b1;
    waited  = 0;
    while (!i_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("frame_accept", 32'(i_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // latency counted in negedges after the reference edge (1 = first negedge)
  task automatic wait_out(input logic exp_left, input int exp_pos, input int exp_lat);
    int n;
    n = 1;
    while (!o_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("o_valid", 32'(o_valid), 32'd1);
    if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
    check("o_is_left", 32'(o_is_left), 32'(exp_left));
    check("o_position", 32'(o_position), 32'(exp_pos));
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_is_left", 32'(o_is_left), 32'd0);
    check("rst_o_position", 32'(o_position), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_i_ready", 32'(i_ready), 32'd1);

    // full-scale: 0x7FFF -> 30 (2 scan cycles), 0x8000 -> 31 (1 scan cycle)
    send_frame(16'h7FFF, 16'h8000, stall);
    send_frame(16'h0000, 16'h0000, stall);
    i_valid = 1'b0;
    wait_out(1'b1, 30, 4);
    @(negedge clk);
    wait_out(1'b0, 31, 2);
    @(negedge clk);

    // negative sample -3 dominates: peak 3 -> 4 on both channels
    send_frame(16'h0001, 16'h0003, stall);
    send_frame(16'hFFFD, 16'h0000, stall);
    i_valid = 1'b0;
    wait_out(1'b1, 4, 17);
    @(negedge clk);
    wait_out(1'b0, 4, 16);
    @(negedge clk);

    // silence: full 16-cycle scan, position 0
    send_frame(16'h0000, 16'h0000, stall);
    send_frame(16'h0000, 16'h0000, stall);
    i_valid = 1'b0;
    wait_out(1'b1, 0, 18);
    @(negedge clk);
    wait_out(1'b0, 0, 17);
    @(negedge clk);

    // downstream stall holds left output stable
    o_ready = 1'b0;
    send_frame(16'h00C0, 16'h0001, stall);
    send_frame(16'h0000, 16'h0000, stall);
    i_valid = 1'b0;
    wait_out(1'b1, 16, 11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_is_left", 32'(o_is_left), 32'd1);
      check("stall_position", 32'(o_position), 32'd16);
    end
    o_ready = 1'b1;
    @(negedge clk);
    wait_out(1'b0, 1, 17);
    @(negedge clk);

    // continuous input under back-pressure: closing frame held, none lost
    o_ready = 1'b0;
    base = accepted;
    send_frame(16'h0100, 16'h0100, stall);
    send_frame(16'h0000, 16'h0000, stall);
    send_frame(16'h0010, 16'h0002, stall);
    fork
      begin
        int held;
        send_frame(16'h0004, 16'h0020, held);
        check("close_held", 32'(held > 15), 32'd1);
      end
      begin
        repeat (15) @(negedge clk);
        check("bp_i_ready", 32'(i_ready), 32'd0);
        check("bp_o_valid", 32'(o_valid), 32'd1);
        check("bp_left_pos", 32'(o_position), 32'd17);
        o_ready = 1'b1;
        @(negedge clk);
        check("bp_i_ready_right", 32'(i_ready), 32'd0);
        wait_out(1'b0, 17, -1);
      end
    join
    i_valid = 1'b0;
    wait_out(1'b1, 9, 14);
    @(negedge clk);
    wait_out(1'b0, 11, 12);
    check("frames_accepted", 32'(accepted - base), 32'd4);
    @(negedge clk);

    // reset mid-handshake and mid-window discards everything
    o_ready = 1'b0;
    send_frame(16'h0100, 16'h0000, stall);
    send_frame(16'h0000, 16'h0000, stall);
    send_frame(16'h7000, 16'h7000, stall);
    i_valid = 1'b0;
    wait_out(1'b1, 17, -1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_o_valid", 32'(o_valid), 32'd0);
    check("mid_rst_i_ready", 32'(i_ready), 32'd0);
    check("mid_rst_position", 32'(o_position), 32'd0);
    reset = 1'b1;
    o_ready = 1'b1;
    @(negedge clk);
    check("rel_i_ready", 32'(i_ready), 32'd1);
    send_frame(16'h0004, 16'hFFFF, stall);
    send_frame(16'h0000, 16'h0000, stall);
    i_valid = 1'b0;
    wait_out(1'b1, 5, 16);
    @(negedge clk);
    wait_out(1'b0, 1, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
